// File: rtl/johnson_seq_monitor.sv
// johnson_seq_monitor
//   Receive-side checker for a Johnson counter stream. Each valid cycle it
//   decodes in_code to a position and a one-hot count. It flags illegal words
//   and wrong successors, and it tracks lock over consecutive correct steps.
//   Every output is registered, so the response appears one cycle after the
//   sampling edge.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, highest priority
//   in_valid     in_code is sampled this cycle
//   in_code      Johnson code word, MSB-first
//   pos_valid    pulse: pos/onehot updated from a legal sample
//   pos          decoded position 0..N-1
//   onehot       one-hot count, bit (N-1-pos) set; cleared on illegal sample
//   locked       LOCK_CNT consecutive correct steps seen since the anchor
//   err_illegal  pulse: illegal code sampled
//   err_seq      pulse: legal code that is not the expected successor
//   err_count    saturating count of all error pulses
module johnson_seq_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  localparam int N  = 2 * WIDTH,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_code,
  output logic             pos_valid,
  output logic [PW-1:0]    pos,
  output logic [N-1:0]     onehot,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [ERR_W-1:0] err_count
);

  localparam int RW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

  state_t        state;
  logic [RW-1:0] run;
  logic          have_prev;

  // Code word of position p: positions up to WIDTH fill ones from the MSB,
  // and later positions drain them from the MSB, leaving ones at the LSB end.
  function automatic logic [WIDTH-1:0] code_of(input int p);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int b = 0; b < WIDTH; b++)
      c[b] = (p <= WIDTH) ? (b >= WIDTH - p) : (b < N - p);
    return c;
  endfunction

  logic          dec_legal;
  logic [PW-1:0] dec_pos;
  logic [N-1:0]  dec_onehot;
  logic [PW-1:0] nxt_pos;
  logic          step_ok;
  logic          seq_bad;
  logic          err_evt;

  always_comb begin
    dec_legal  = 1'b0;
    dec_pos    = '0;
    dec_onehot = '0;
    for (int p = 0; p < N; p++) begin
      if (in_code == code_of(p)) begin
        dec_legal         = 1'b1;
        dec_pos           = PW'(p);
        dec_onehot        = '0;
        dec_onehot[N-1-p] = 1'b1;
      end
    end
  end

  // The pos register doubles as the previous position; have_prev says
  // whether it holds a usable anchor.
  assign nxt_pos = (pos == PW'(N - 1)) ? '0 : pos + 1'b1;
  assign step_ok = (dec_pos == nxt_pos);
  assign seq_bad = have_prev && !step_ok;
  assign err_evt = in_valid && (!dec_legal || seq_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      run         <= '0;
      have_prev   <= 1'b0;
      pos_valid   <= 1'b0;
      pos         <= '0;
      onehot      <= '0;
      locked      <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_count   <= '0;
    end else begin
      pos_valid   <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      if (err_evt && err_count != '1)
        err_count <= err_count + 1'b1;
      if (in_valid) begin
        if (!dec_legal) begin
          // pos holds on purpose. The anchor is dropped, so the next legal
          // word re-anchors without a sequence error.
          err_illegal <= 1'b1;
          onehot      <= '0;
          have_prev   <= 1'b0;
          state       <= UNLOCKED;
          run         <= '0;
          locked      <= 1'b0;
        end else begin
          pos_valid <= 1'b1;
          pos       <= dec_pos;
          onehot    <= dec_onehot;
          have_prev <= 1'b1;
          case (state)
            UNLOCKED: begin
              state  <= LOCKING;
              run    <= '0;
              locked <= 1'b0;
            end
            LOCKING: begin
              if (seq_bad) begin
                err_seq <= 1'b1;
                run     <= '0;
              end else if (run == RW'(LOCK_CNT - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                run    <= '0;
              end else begin
                run <= run + 1'b1;
              end
            end
            LOCKED: begin
              if (seq_bad) begin
                err_seq <= 1'b1;
                state   <= LOCKING;
                run     <= '0;
                locked  <= 1'b0;
              end
            end
            default: begin
              state  <= UNLOCKED;
              run    <= '0;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
